// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-style core: opcodes, FSM states,
// ALU operations, next-PC and destination-register selects.
package multi_cycle_ctrl_pkg;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    function automatic logic is_rtype(input logic [5:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_OR ||
               op == OP_AND || op == OP_SLL || op == OP_SLT;
    endfunction

    function automatic logic is_alu_op(input logic [5:0] op);
        return is_rtype(op) || op == OP_ADDI || op == OP_ORI;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: only the state is registered, all control
// outputs decode combinationally from state, opcode and zero.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [2:0] state
);

    state_t r_state;
    state_t w_next;
    logic   r_run;

    logic w_alu, w_br, w_ls, w_take;
    logic w_pcw, w_rgw;
    logic [1:0] w_pcs;

    assign w_alu  = is_alu_op(opcode);
    assign w_br   = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign w_ls   = (opcode == OP_LW) || (opcode == OP_SW);
    assign w_take = (opcode == OP_BEQ && zero) ||
                    (opcode == OP_BNE && !zero);

    // First edge after reset release holds IF so its outputs are seen once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IF;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run)
                r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF: w_next = S_ID;
            S_ID: begin
                if (w_alu)
                    w_next = S_EXE_AL;
                else if (w_br)
                    w_next = S_EXE_BR;
                else if (w_ls)
                    w_next = S_EXE_LS;
                else
                    w_next = S_IF;
            end
            S_EXE_AL: w_next = S_WB_AL;
            S_EXE_LS: w_next = S_MEM;
            S_MEM:    w_next = (opcode == OP_LW) ? S_WB_LD : S_IF;
            default:  w_next = S_IF;
        endcase
    end

    always_comb begin
        w_pcw = 1'b0;
        w_rgw = 1'b0;
        w_pcs = PC_NEXT;
        case (r_state)
            S_ID: begin
                w_pcw = !(w_alu || w_br || w_ls || opcode == OP_HALT);
                w_rgw = (opcode == OP_JAL);
                if (opcode == OP_J || opcode == OP_JAL)
                    w_pcs = PC_JUMP;
                else if (opcode == OP_JR)
                    w_pcs = PC_REG;
            end
            S_EXE_BR: begin
                w_pcw = 1'b1;
                if (w_take)
                    w_pcs = PC_BRANCH;
            end
            S_MEM:   w_pcw = (opcode == OP_SW);
            S_WB_AL: begin
                w_pcw = 1'b1;
                w_rgw = 1'b1;
            end
            S_WB_LD: begin
                w_pcw = 1'b1;
                w_rgw = 1'b1;
            end
            default: ;
        endcase

        RegDst = RD_RA;
        if (is_rtype(opcode))
            RegDst = RD_RD;
        else if (opcode == OP_ADDI || opcode == OP_ORI || opcode == OP_LW)
            RegDst = RD_RT;

        ALUOp = ALU_ADD;
        case (opcode)
            OP_SUB, OP_BEQ, OP_BNE: ALUOp = ALU_SUB;
            OP_OR, OP_ORI:          ALUOp = ALU_OR;
            OP_AND:                 ALUOp = ALU_AND;
            OP_SLL:                 ALUOp = ALU_SLL;
            OP_SLT:                 ALUOp = ALU_SLT;
            default:                ALUOp = ALU_ADD;
        endcase
    end

    assign PCWre     = w_pcw && !reset;
    assign PCSrc     = PCWre ? w_pcs : PC_NEXT;
    assign IRWre     = (r_state == S_IF) && !reset;
    assign RegWre    = w_rgw && !reset;
    assign WrRegDSrc = (opcode != OP_JAL);
    assign ALUSrcA   = (opcode == OP_SLL);
    assign ALUSrcB   = (opcode == OP_ADDI) || (opcode == OP_ORI) || w_ls;
    assign ExtSel    = (opcode != OP_ORI);
    assign mWR       = (r_state == S_MEM) && (opcode == OP_SW) && !reset;
    assign mRD       = (r_state == S_MEM || r_state == S_WB_LD) &&
                       (opcode == OP_LW) && !reset;
    assign DBDataSrc = (opcode == OP_LW);
    assign state     = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: static decode table, per-cycle
// control table, then halt looping and mid-MEM reset sequences.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       PCWre, IRWre, RegWre, WrRegDSrc;
    logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int n_cmp = 0;
    int n_bad = 0;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .mRD(mRD),
        .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state)
    );

    always #5 clk = ~clk;

    // {state, PCWre, PCSrc, IRWre, RegWre, mRD, mWR}
    localparam logic [9:0] C_IF     = 10'b000_0_00_1_0_0_0;
    localparam logic [9:0] C_ID     = 10'b001_0_00_0_0_0_0;
    localparam logic [9:0] C_EXAL   = 10'b110_0_00_0_0_0_0;
    localparam logic [9:0] C_WBAL   = 10'b111_1_00_0_1_0_0;
    localparam logic [9:0] C_BR_T   = 10'b101_1_01_0_0_0_0;
    localparam logic [9:0] C_BR_N   = 10'b101_1_00_0_0_0_0;
    localparam logic [9:0] C_EXLS   = 10'b010_0_00_0_0_0_0;
    localparam logic [9:0] C_MEM_LW = 10'b011_0_00_0_0_1_0;
    localparam logic [9:0] C_WBLD   = 10'b100_1_00_0_1_1_0;
    localparam logic [9:0] C_MEM_SW = 10'b011_1_00_0_0_0_1;
    localparam logic [9:0] C_ID_JAL = 10'b001_1_11_0_1_0_0;
    localparam logic [9:0] C_ID_JR  = 10'b001_1_10_0_0_0_0;
    localparam logic [9:0] C_ID_J   = 10'b001_1_11_0_0_0_0;
    localparam logic [9:0] C_ID_UNK = 10'b001_1_00_0_0_0_0;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic [9:0] ctl;
    } cyc_t;

    // {RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, DBDataSrc}
    typedef struct {
        logic [5:0] op;
        logic [9:0] dec;
        logic [9:0] mask;
    } dec_t;

    cyc_t seq[$];
    dec_t dtab[$];

    task automatic add_cyc(input logic [5:0] op, input logic z,
                           input logic [9:0] ctl);
        cyc_t c;
        c.op = op; c.z = z; c.ctl = ctl;
        seq.push_back(c);
    endtask

    task automatic add_dec(input logic [5:0] op, input logic [9:0] dec,
                           input logic [9:0] mask);
        dec_t d;
        d.op = op; d.dec = dec; d.mask = mask;
        dtab.push_back(d);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] ctl_now();
        return {state, PCWre, PCSrc, IRWre, RegWre, mRD, mWR};
    endfunction

    function automatic logic [9:0] dec_now();
        return {RegDst, WrRegDSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel, DBDataSrc};
    endfunction

    initial begin
        bit hit;
        add_dec(6'b000000, 10'b10_1_0_0_000_1_0, 10'h3FF);
        add_dec(6'b000001, 10'b10_1_0_0_001_1_0, 10'h3FF);
        add_dec(6'b000010, 10'b01_1_0_1_000_1_0, 10'h3FF);
        add_dec(6'b010000, 10'b10_1_0_0_011_1_0, 10'h3FF);
        add_dec(6'b010001, 10'b10_1_0_0_100_1_0, 10'h3FF);
        add_dec(6'b010010, 10'b01_1_0_1_011_0_0, 10'h3FF);
        add_dec(6'b011000, 10'b10_1_1_0_010_1_0, 10'h3FF);
        add_dec(6'b100110, 10'b10_1_0_0_110_1_0, 10'h3FF);
        add_dec(6'b110000, 10'b00_1_0_1_000_1_0, 10'h0FF);
        add_dec(6'b110001, 10'b01_1_0_1_000_1_1, 10'h3FF);
        add_dec(6'b110100, 10'b00_1_0_0_001_1_0, 10'h0FF);
        add_dec(6'b110101, 10'b00_1_0_0_001_1_0, 10'h0FF);
        add_dec(6'b111010, 10'b00_0_0_0_000_1_0, 10'h3E3);
        add_dec(6'b111001, 10'b00_1_0_0_000_1_0, 10'h0E3);
        add_dec(6'b111000, 10'b00_1_0_0_000_1_0, 10'h0E3);

        add_cyc(6'b000000, 1'b1, C_IF);
        add_cyc(6'b000000, 1'b1, C_ID);
        add_cyc(6'b000000, 1'b1, C_EXAL);
        add_cyc(6'b000000, 1'b1, C_WBAL);
        add_cyc(6'b110100, 1'b1, C_IF);
        add_cyc(6'b110100, 1'b1, C_ID);
        add_cyc(6'b110100, 1'b1, C_BR_T);
        add_cyc(6'b110100, 1'b0, C_IF);
        add_cyc(6'b110100, 1'b0, C_ID);
        add_cyc(6'b110100, 1'b0, C_BR_N);
        add_cyc(6'b110101, 1'b1, C_IF);
        add_cyc(6'b110101, 1'b1, C_ID);
        add_cyc(6'b110101, 1'b1, C_BR_N);
        add_cyc(6'b110101, 1'b0, C_IF);
        add_cyc(6'b110101, 1'b0, C_ID);
        add_cyc(6'b110101, 1'b0, C_BR_T);
        add_cyc(6'b110001, 1'b0, C_IF);
        add_cyc(6'b110001, 1'b0, C_ID);
        add_cyc(6'b110001, 1'b0, C_EXLS);
        add_cyc(6'b110001, 1'b0, C_MEM_LW);
        add_cyc(6'b110001, 1'b0, C_WBLD);
        add_cyc(6'b110000, 1'b1, C_IF);
        add_cyc(6'b110000, 1'b1, C_ID);
        add_cyc(6'b110000, 1'b1, C_EXLS);
        add_cyc(6'b110000, 1'b1, C_MEM_SW);
        add_cyc(6'b111010, 1'b1, C_IF);
        add_cyc(6'b111010, 1'b1, C_ID_JAL);
        add_cyc(6'b111001, 1'b0, C_IF);
        add_cyc(6'b111001, 1'b0, C_ID_JR);
        add_cyc(6'b111000, 1'b0, C_IF);
        add_cyc(6'b111000, 1'b0, C_ID_J);
        add_cyc(6'b101010, 1'b1, C_IF);
        add_cyc(6'b101010, 1'b1, C_ID_UNK);
        add_cyc(6'b010010, 1'b1, C_IF);
        add_cyc(6'b010010, 1'b1, C_ID);
        add_cyc(6'b010010, 1'b1, C_EXAL);
        add_cyc(6'b010010, 1'b1, C_WBAL);

        reset = 1'b1;
        opcode = 6'b110001;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", 32'(ctl_now()), 32'(10'b000_0_00_0_0_0_0));

        foreach (dtab[i]) begin
            opcode = dtab[i].op;
            #1;
            chk($sformatf("decode[%0d] op=%b", i, dtab[i].op),
                32'(dec_now() & dtab[i].mask),
                32'(dtab[i].dec & dtab[i].mask));
            chk($sformatf("decode_rst_ctl[%0d]", i),
                32'(ctl_now()), 32'(10'b000_0_00_0_0_0_0));
        end

        @(negedge clk);
        reset = 1'b0;

        foreach (seq[i]) begin
            @(negedge clk);
            opcode = seq[i].op;
            zero = seq[i].z;
            #1;
            chk($sformatf("cycle[%0d] op=%b z=%b", i, seq[i].op, seq[i].z),
                32'(ctl_now()), 32'(seq[i].ctl));
        end

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            opcode = 6'b111111;
            #1;
            chk($sformatf("halt_state[%0d]", k), 32'(state),
                (k % 2 == 0) ? 32'd0 : 32'd1);
            chk($sformatf("halt_pcwre[%0d]", k), 32'(PCWre), 32'd0);
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            opcode = 6'b110000;
            #1;
        end
        chk("sw_mem_before_rst", 32'(ctl_now()), 32'(C_MEM_SW));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ctl", 32'(ctl_now()), 32'(10'b000_0_00_0_0_0_0));

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_if", 32'(ctl_now()), 32'(C_IF));
        @(negedge clk);
        #1;
        chk("first_edge_if", 32'(ctl_now()), 32'(C_IF));
        @(negedge clk);
        #1;
        chk("second_edge_id", 32'(state), 32'd1);

        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (state == 3'b011)
                hit = 1'b1;
            else
                chk($sformatf("no_mwr_before_mem[%0d]", k), 32'(mWR), 32'd0);
        end
        chk("sw_reaches_mem", 32'(hit), 32'd1);
        chk("sw_mem_after_rst", 32'(ctl_now()), 32'(C_MEM_SW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL use one clock and one reset: clk (rising edge); reset is asynchronous and active-high.
REQ-002 SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- opcode  in  6  IR[31:26], stable from ID onward
- zero  in  1  ALU result == 0
- PCWre  out  1  PC write enable to the PC register
- PCSrc  out  2  next-PC select: 00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target
- IRWre  out  1  instruction-register write enable
- RegWre  out  1  register-file write enable
- RegDst  out  2  destination select: 00 $31, 01 rt, 10 rd
- WrRegDSrc  out  1  reg write data: 0 PC+4, 1 ALU/memory path
- ALUSrcA  out  1  1 selects shamt (sll)
- ALUSrcB  out  1  1 selects extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt
- ExtSel  out  1  1 sign-extend, 0 zero-extend
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- DBDataSrc  out  1  1 selects memory data for writeback
- state  out  3  current state, for debug

Function
REQ-003 SHALL decode these opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111.
REQ-004 SHALL encode states as: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
REQ-005 SHALL register the state only; all outputs SHALL be combinational from state, opcode and zero.
REQ-006 SHALL follow these transitions:
- IF -> ID.
- ID -> EXE_AL for ALU ops.
- ID -> EXE_BR for beq/bne.
- ID -> EXE_LS for lw/sw.
- ID -> IF for j, jr, jal, halt and unknown opcodes.
- EXE_AL -> WB_AL -> IF.
- EXE_BR -> IF.
- EXE_LS -> MEM.
- MEM -> IF for sw; MEM -> WB_LD for lw.
- WB_LD -> IF.
REQ-007 SHALL assert IRWre only in IF.
REQ-008 SHALL assert PCWre for exactly one cycle per instruction: the final cycle.
- That cycle is ID for j/jr/jal/unknown, WB_AL, EXE_BR, MEM for sw, and WB_LD.
- PCWre SHALL be 0 in every other state.
REQ-009 SHALL keep PCWre at 0 for halt, so the PC holds and halt re-executes IF->ID indefinitely.
REQ-010 SHALL drive PCSrc in the PCWre cycle as follows:
- j, jal: 11.
- jr: 10.
- beq: 01 when zero=1, else 00.
- bne: 01 when zero=0, else 00.
- all others: 00.
REQ-011 SHALL drive PCSrc=00 whenever PCWre=0.
REQ-012 SHALL handle jal in ID with RegWre=1, RegDst=00, WrRegDSrc=0 in the same cycle as PCWre.
REQ-013 SHALL assert RegWre only in WB_AL, WB_LD and the jal ID cycle.
REQ-014 SHALL set RegDst=10 for R-type ALU ops (add/sub/or/and/sll/slt) and RegDst=01 for addi/ori/lw.
REQ-015 SHALL assert mWR only in MEM for sw, and mRD only in MEM and WB_LD for lw.
REQ-016 SHALL assert DBDataSrc=1 only for lw.
REQ-017 SHALL set ALUSrcB=1 for addi, ori, lw and sw.
REQ-018 SHALL set ALUSrcA=1 for sll.
REQ-019 SHALL set ExtSel=0 for ori and ExtSel=1 otherwise.
REQ-020 SHALL set ALUOp per REQ-002:
- beq/bne use sub.
- addi/lw/sw use add.
- ori uses or.
REQ-021 SHALL hold ALUOp, ALUSrcA/B and ExtSel at their decoded values across all states of an instruction.
REQ-022 SHALL treat unknown opcodes as nop: no register or memory write, PCSrc=00.

Reset
REQ-023 SHALL, while reset=1 and independent of clk, force state=IF and drive PCWre, RegWre, mWR, mRD and IRWre to 0.
REQ-024 SHALL, on reset assertion mid-instruction (any state), abandon the instruction with no partial writes.
REQ-025 SHALL, on the first rising clk edge after reset deasserts, present IF outputs (IRWre=1) and enter ID on the following edge.

Structure
REQ-026 SHALL place opcode constants, state encodings, ALUOp codes and PCSrc codes in a shared package, also used by the decode, ALU and datapath blocks.
REQ-027 SHALL be a single module with no sub-modules; the next-state and output decode are separate combinational processes.

Verification
REQ-028 SHALL cover: add (000000) after reset -> states IF,ID,EXE_AL,WB_AL; RegWre=1 and RegDst=10 in WB_AL; PCWre=1, PCSrc=00 only in WB_AL.
REQ-029 SHALL cover: beq with zero=1 in EXE_BR -> PCWre=1, PCSrc=01; repeated with zero=0 -> PCSrc=00; bne inverts both.
REQ-030 SHALL cover: lw -> 5 cycles IF,ID,EXE_LS,MEM,WB_LD; mRD=1 in MEM and WB_LD; RegWre=1, DBDataSrc=1 in WB_LD. sw -> 4 cycles, mWR=1 in MEM only.
REQ-031 SHALL cover: jal -> 2 cycles; in ID, PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0. jr -> PCSrc=10.
REQ-032 SHALL cover: halt (111111) -> IF/ID alternate for 20 cycles with PCWre never 1.
REQ-033 SHALL cover: reset asserted mid-clock while in MEM for sw -> mWR falls immediately, state=000; no mWR pulse after release until the next sw reaches MEM.
